// File: rtl/mdio_sta_multi.sv
`default_nettype none
// ============================================================================
// Module      : mdio_sta_multi
// Description : MDIO station-management master. Serialises one Clause 22 or
//               Clause 45 management frame per start strobe onto MDC/MDIO,
//               with configurable MDC divider and preamble length.
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_sta_multi #(
    parameter int CLK_DIV = 4,
    parameter int PRE_LEN = 32,
    parameter bit C45_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stb,
    input  logic [1:0]  ST,
    input  logic [1:0]  OP,
    input  logic [4:0]  PHYADDR,
    input  logic [4:0]  REGADDR,
    input  logic [15:0] WR_DATA,
    output logic [15:0] RD_DATA,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oe,
    input  logic        mdio_in
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4,
        S_END  = 3'd5
    } state_t;

    localparam int                 c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(CLK_DIV - 1);
    // Frame bit indices, counted from the first preamble bit
    localparam logic [6:0]         c_HDR0    = 7'(PRE_LEN);
    localparam logic [6:0]         c_TA0     = 7'(PRE_LEN + 14);
    localparam logic [6:0]         c_TA1     = 7'(PRE_LEN + 15);
    localparam logic [6:0]         c_DAT0    = 7'(PRE_LEN + 16);
    localparam logic [6:0]         c_LAST    = 7'(PRE_LEN + 31);
    localparam state_t             c_FIRST   = (PRE_LEN > 0) ? S_PRE : S_HDR;

    state_t             r_state;
    logic [c_DIV_W-1:0] r_div;
    logic               r_phase;     // 0 = MDC low phase, 1 = MDC high phase
    logic [6:0]         r_bit;
    logic [31:0]        r_frame;     // header, TA and data; MSB is the current bit
    logic               r_is_read;
    logic               r_ta2;
    logic [15:0]        r_rd_shift;

    logic               w_legal;
    logic               w_read;
    logic               w_first_out;
    logic [6:0]         w_nbit;
    state_t             w_nstate;
    logic               w_nout;
    logic               w_noe;
    logic               w_sample;
    logic [15:0]        w_rd_next;

    // Request decode and next-bit drive values
    always_comb begin
        w_legal     = ((ST == 2'b01) && ((OP == 2'b01) || (OP == 2'b10))) ||
                      (C45_EN && (ST == 2'b00));
        w_read      = ((ST == 2'b01) && (OP == 2'b10)) || ((ST == 2'b00) && OP[1]);
        w_first_out = (PRE_LEN > 0) ? 1'b1 : ST[1];
        w_nbit      = r_bit + 7'd1;
        w_nstate    = r_state;
        case (r_state)
            S_PRE:   if (w_nbit == c_HDR0) w_nstate = S_HDR;
            S_HDR:   if (w_nbit == c_TA0)  w_nstate = S_TA;
            S_TA:    if (w_nbit == c_DAT0) w_nstate = S_DATA;
            default: w_nstate = r_state;
        endcase
        // Leaving the preamble the frame MSB is next; otherwise the bit behind it
        w_nout    = (w_nstate == S_PRE) ? 1'b1 :
                    (r_state == S_PRE)  ? r_frame[31] : r_frame[30];
        // Reads release the bus from the first TA bit to the end of the frame
        w_noe     = !(r_is_read && ((w_nstate == S_TA) || (w_nstate == S_DATA)));
        // Capture point: end of the first clk cycle with MDC high
        w_sample  = r_is_read && r_phase && (r_div == '0);
        w_rd_next = (w_sample && (r_state == S_DATA)) ? {r_rd_shift[14:0], mdio_in}
                                                      : r_rd_shift;
    end

    // Frame sequencer: accept, MDC generation, bit drive, read capture, completion
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_phase    <= 1'b0;
            r_bit      <= 7'd0;
            r_frame    <= 32'd0;
            r_is_read  <= 1'b0;
            r_ta2      <= 1'b0;
            r_rd_shift <= 16'd0;
            RD_DATA    <= 16'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mdc        <= 1'b0;
            mdio_out   <= 1'b1;
            mdio_oe    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                S_IDLE, S_END: begin
                    r_state <= S_IDLE;
                    if (start_stb) begin
                        if (w_legal) begin
                            r_state    <= c_FIRST;
                            r_frame    <= {ST, OP, PHYADDR, REGADDR, 2'b10, WR_DATA};
                            r_is_read  <= w_read;
                            r_ta2      <= 1'b0;
                            r_rd_shift <= 16'd0;
                            r_div      <= '0;
                            r_phase    <= 1'b0;
                            r_bit      <= 7'd0;
                            busy       <= 1'b1;
                            mdc        <= 1'b0;
                            mdio_oe    <= 1'b1;
                            mdio_out   <= w_first_out;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_rd_shift <= w_rd_next;
                    if (w_sample && (r_state == S_TA) && (r_bit == c_TA1)) begin
                        r_ta2 <= mdio_in;
                    end
                    if (r_div == c_DIV_MAX) begin
                        r_div <= '0;
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                            mdc     <= 1'b1;
                        end else if (r_bit == c_LAST) begin
                            r_state  <= S_END;
                            r_phase  <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            mdc      <= 1'b0;
                            mdio_oe  <= 1'b0;
                            mdio_out <= 1'b1;
                            if (r_is_read) begin
                                RD_DATA <= w_rd_next;
                                err     <= r_ta2;
                            end
                        end else begin
                            r_state  <= w_nstate;
                            r_bit    <= w_nbit;
                            r_phase  <= 1'b0;
                            mdc      <= 1'b0;
                            mdio_out <= w_nout;
                            mdio_oe  <= w_noe;
                            if (r_state != S_PRE) begin
                                r_frame <= {r_frame[30:0], 1'b0};
                            end
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
